// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// global stall, flush (bubble insertion or empty), and saturating stall/flush counters.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W       = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = DATA_W'(32'h0000_0013),
    parameter bit                EMIT_BUBBLE  = 1'b1,
    parameter int unsigned       CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_bub_q, main_bub_d;
    logic              skid_bub_q, skid_bub_d;
    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic eff_flush;
    logic in_fire;
    logic out_fire;

    // A flush seen while stalled is remembered and takes effect on the first free cycle.
    assign eff_flush = (flush || flush_pend_q) && !stall;
    assign in_ready  = (count_q != 2'd2) && !stall && !eff_flush;
    assign out_valid = (count_q != 2'd0) && !stall;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_data   = main_q;
    assign out_bubble = main_bub_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

    always_comb begin
        count_d      = count_q;
        main_d       = main_q;
        skid_d       = skid_q;
        main_bub_d   = main_bub_q;
        skid_bub_d   = skid_bub_q;
        flush_pend_d = flush_pend_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        if (stall) begin
            flush_pend_d = flush_pend_q || flush;
            if (!(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (eff_flush) begin
            flush_pend_d = 1'b0;
            if (!(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            if (EMIT_BUBBLE) begin
                count_d    = 2'd1;
                main_d     = BUBBLE_VALUE;
                main_bub_d = 1'b1;
                skid_bub_d = 1'b0;
            end else begin
                count_d = 2'd0;
            end
        end else begin
            case ({in_fire, out_fire})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        main_d     = in_data;
                        main_bub_d = 1'b0;
                    end else begin
                        main_d     = skid_q;
                        main_bub_d = skid_bub_q;
                        skid_d     = in_data;
                        skid_bub_d = 1'b0;
                    end
                end
                2'b10: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        main_d     = in_data;
                        main_bub_d = 1'b0;
                    end else begin
                        skid_d     = in_data;
                        skid_bub_d = 1'b0;
                    end
                end
                2'b01: begin
                    count_d = count_q - 2'd1;
                    if (count_q == 2'd2) begin
                        main_d     = skid_q;
                        main_bub_d = skid_bub_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= 2'd0;
            main_q       <= '0;
            skid_q       <= '0;
            main_bub_q   <= 1'b0;
            skid_bub_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            count_q      <= count_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_bub_q   <= main_bub_d;
            skid_bub_q   <= skid_bub_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboarded bench for pipe_stage_reg: directed vectors, monitor pops expected
// payloads whenever the stage hands one downstream.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_bubble;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              bub;
    } exp_t;

    exp_t sb_q[$];
    int   nvec = 0;
    int   nerr = 0;

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .BUBBLE_VALUE(32'h0000_0013),
        .EMIT_BUBBLE (1'b1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bubble(out_bubble),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge; return at the falling edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic ordy,
                       input logic st, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d, input logic b);
        exp_t e;
        e.data = d;
        e.bub  = b;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL mon_unexpected: got %0h with empty scoreboard", out_data);
            end else begin
                e = sb_q.pop_front();
                nvec++;
                if (out_data !== e.data || out_bubble !== e.bub) begin
                    nerr++;
                    $display("FAIL mon_data: got %0h/%0b expected %0h/%0b",
                             out_data, out_bubble, e.data, e.bub);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_bubble", 32'(out_bubble), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (i == 1) chk("stream_latency", 32'(out_valid), 32'd0);
            push(32'(i), 1'b0);
        end
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("stream_last_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("stream_drained", 32'(out_valid), 32'd0);

        // back-pressure A,B,C
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_a", 32'(in_ready), 32'd1);
        push(32'hA, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_b", 32'(in_ready), 32'd1);
        push(32'hB, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("bp_full", 32'(in_ready), 32'd0);
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        chk("bp_full_release", 32'(in_ready), 32'd0);
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        chk("bp_ready_c", 32'(in_ready), 32'd1);
        push(32'hC, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // flush with two entries held
        cyc(1'b1, 32'h1111, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h2222, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3333, 1'b0, 1'b0, 1'b1);
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        chk("fl_cnt_before", 32'(flush_cnt), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("fl_valid", 32'(out_valid), 32'd1);
        chk("fl_data", out_data, 32'h13);
        chk("fl_bubble", 32'(out_bubble), 32'd1);
        chk("fl_cnt", 32'(flush_cnt), 32'd1);
        push(32'h13, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("fl_only_bubble", 32'(out_valid), 32'd0);

        // flush pulsed during a 4-cycle stall
        cyc(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("st_out_valid", 32'(out_valid), 32'd0);
        chk("st_in_ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("st_cnt_mid", 32'(stall_cnt), 32'd3);
        chk("st_flush_frozen", 32'(flush_cnt), 32'd1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("st_cnt", 32'(stall_cnt), 32'd4);
        chk("st_pend_blocks_in", 32'(in_ready), 32'd0);
        chk("st_held_data", out_data, 32'hD1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("st_bub_valid", 32'(out_valid), 32'd1);
        chk("st_bub_data", out_data, 32'h13);
        chk("st_bub_flag", 32'(out_bubble), 32'd1);
        chk("st_flush_cnt", 32'(flush_cnt), 32'd2);
        push(32'h13, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("st_drained", 32'(out_valid), 32'd0);

        // stall counter saturation
        for (int i = 0; i < 20; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        chk("sat_flush_cnt", 32'(flush_cnt), 32'd2);

        // asynchronous reset with two entries held
        cyc(1'b1, 32'hE, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hF, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_data", out_data, 32'hE);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_out_data", out_data, 32'd0);
        chk("ar_out_bubble", 32'(out_bubble), 32'd0);
        chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("ar_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("ar_after_valid", 32'(out_valid), 32'd0);

        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
